// File: rtl/mem_load_stage_pkg.sv
// Shared types and constants for the memory-load stage and its helpers.
package common_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // Reserved size encoding 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = addr_lo[0];
            default: r = (addr_lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_load_stage_if.sv
// Execute-side inputs, data-memory read bus and writeback outputs of the load stage.
interface mem_load_stage_if #(
    parameter int ADDR_W = 32
);
    logic              ex_valid;
    logic [31:0]       ex_result;
    logic [4:0]        ex_reg_dest;
    logic              ex_write_en;
    logic              ex_mem_read;
    logic [1:0]        ex_mem_size;
    logic              ex_mem_signed;
    logic              flush;
    logic              mem_stall;
    logic              dmem_req;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic [31:0]       wb_result;
    logic [4:0]        wb_reg_dest;
    logic              wb_write_en;
    logic              addr_error;

    modport master (
        output ex_valid, ex_result, ex_reg_dest, ex_write_en, ex_mem_read,
               ex_mem_size, ex_mem_signed, flush, dmem_ack, dmem_rdata,
        input  mem_stall, dmem_req, dmem_addr, wb_result, wb_reg_dest,
               wb_write_en, addr_error
    );

    modport slave (
        input  ex_valid, ex_result, ex_reg_dest, ex_write_en, ex_mem_read,
               ex_mem_size, ex_mem_signed, flush, dmem_ack, dmem_rdata,
        output mem_stall, dmem_req, dmem_addr, wb_result, wb_reg_dest,
               wb_write_en, addr_error
    );

endinterface

// File: rtl/mem_load_stage_extract.sv
// load_extract: picks the addressed byte/half/word from a little-endian read word and extends it.
module load_extract
    import common_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  mem_size_t   i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_load_stage.sv
// mem_load_stage: load-only memory stage feeding writeback, with a req/ack data-memory handshake.
// Optional misaligned-load trap enabled by defining LOAD_ALIGN_CHECK_EN.
module mem_load_stage
    import common_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst,
    mem_load_stage_if.slave bus
);

    mem_state_t        r_state;
    mem_state_t        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    mem_size_t         r_size;
    logic              r_signed;
    logic [4:0]        r_dest;
    logic              r_we;
    logic              r_killed;

    logic [DATA_W-1:0] r_wb_result;
    logic [4:0]        r_wb_dest;
    logic              r_wb_we;
    logic              r_addr_error;

    mem_size_t         w_ex_size;
    logic              w_ex_load;
    logic              w_misaligned;
    logic              w_load_start;
    logic              w_dmem_req;
    logic              w_mem_stall;
    logic [ADDR_W-1:0] w_dmem_addr;
    logic [1:0]        w_sel_addr_lo;
    mem_size_t         w_sel_size;
    logic              w_sel_signed;
    logic [31:0]       w_load_data;

    assign w_ex_size = mem_size_t'(bus.ex_mem_size);
    assign w_ex_load = bus.ex_valid & bus.ex_mem_read;

`ifdef LOAD_ALIGN_CHECK_EN
    assign w_misaligned = w_ex_load & is_misaligned(bus.ex_result[1:0], bus.ex_mem_size);
`else
    assign w_misaligned = 1'b0;
`endif

    // A flushed or trapping load never reaches the memory bus.
    assign w_load_start = w_ex_load & ~bus.flush & ~w_misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MS_IDLE: if (w_load_start && !bus.dmem_ack) w_next_state = MS_WAIT;
            MS_WAIT: if (bus.dmem_ack)                  w_next_state = MS_IDLE;
            default: w_next_state = MS_IDLE;
        endcase
    end

    always_comb begin
        w_dmem_req  = 1'b0;
        w_mem_stall = 1'b0;
        w_dmem_addr = '0;
        if (!rst) begin
            case (r_state)
                MS_IDLE: begin
                    w_dmem_req  = w_load_start;
                    w_mem_stall = w_load_start & ~bus.dmem_ack;
                    w_dmem_addr = {bus.ex_result[ADDR_W-1:2], 2'b00};
                end
                MS_WAIT: begin
                    w_dmem_req  = 1'b1;
                    w_mem_stall = ~bus.dmem_ack;
                    w_dmem_addr = {r_addr[ADDR_W-1:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

    // Same-cycle acks extract with the live execute fields, late acks with the latched ones.
    assign w_sel_addr_lo = (r_state == MS_WAIT) ? r_addr[1:0] : bus.ex_result[1:0];
    assign w_sel_size    = (r_state == MS_WAIT) ? r_size      : w_ex_size;
    assign w_sel_signed  = (r_state == MS_WAIT) ? r_signed    : bus.ex_mem_signed;

    load_extract u_extract (
        .i_rdata   (bus.dmem_rdata),
        .i_addr_lo (w_sel_addr_lo),
        .i_size    (w_sel_size),
        .i_signed  (w_sel_signed),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_size       <= SIZE_BYTE;
            r_signed     <= 1'b0;
            r_dest       <= '0;
            r_we         <= 1'b0;
            r_killed     <= 1'b0;
            r_wb_result  <= '0;
            r_wb_dest    <= '0;
            r_wb_we      <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            r_addr_error <= 1'b0;
            r_wb_we      <= 1'b0;
            if (r_state == MS_IDLE) begin
                if (bus.ex_valid && !bus.flush) begin
                    if (w_misaligned) begin
                        r_wb_result  <= bus.ex_result;
                        r_wb_dest    <= bus.ex_reg_dest;
                        r_addr_error <= 1'b1;
                    end else if (!bus.ex_mem_read) begin
                        r_wb_result <= bus.ex_result;
                        r_wb_dest   <= bus.ex_reg_dest;
                        r_wb_we     <= bus.ex_write_en & (bus.ex_reg_dest != ZERO_REG);
                    end else if (bus.dmem_ack) begin
                        r_wb_result <= w_load_data;
                        r_wb_dest   <= bus.ex_reg_dest;
                        r_wb_we     <= bus.ex_write_en & (bus.ex_reg_dest != ZERO_REG);
                    end else begin
                        r_addr   <= bus.ex_result[ADDR_W-1:0];
                        r_size   <= w_ex_size;
                        r_signed <= bus.ex_mem_signed;
                        r_dest   <= bus.ex_reg_dest;
                        r_we     <= bus.ex_write_en;
                        r_killed <= 1'b0;
                    end
                end
            end else begin
                // The bus transaction always completes; a kill only drops its data.
                if (bus.dmem_ack) begin
                    if (!r_killed && !bus.flush) begin
                        r_wb_result <= w_load_data;
                        r_wb_dest   <= r_dest;
                        r_wb_we     <= r_we & (r_dest != ZERO_REG);
                    end
                    r_killed <= 1'b0;
                end else if (bus.flush) begin
                    r_killed <= 1'b1;
                end
            end
        end
    end

    assign bus.dmem_req    = w_dmem_req;
    assign bus.mem_stall   = w_mem_stall;
    assign bus.dmem_addr   = w_dmem_addr;
    assign bus.wb_result   = r_wb_result;
    assign bus.wb_reg_dest = r_wb_dest;
    assign bus.wb_write_en = r_wb_we;
    assign bus.addr_error  = r_addr_error;

endmodule

// File: tb/tb_mem_load_stage.sv
// Directed testbench for mem_load_stage with hand-computed expected values.
module tb_mem_load_stage;

    logic clk;
    logic rst;
    int   vectorCount;
    int   failCount;

    mem_load_stage_if #(.ADDR_W(32)) bus ();

    mem_load_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive every execute/memory input, then let combinational outputs settle.
    task automatic applyStimulus(input logic valid, input logic [31:0] result, input logic [4:0] dest,
                                 input logic we, input logic rd, input logic [1:0] size,
                                 input logic sgn, input logic fl, input logic ack,
                                 input logic [31:0] rdata);
        bus.ex_valid      = valid;
        bus.ex_result     = result;
        bus.ex_reg_dest   = dest;
        bus.ex_write_en   = we;
        bus.ex_mem_read   = rd;
        bus.ex_mem_size   = size;
        bus.ex_mem_signed = sgn;
        bus.flush         = fl;
        bus.dmem_ack      = ack;
        bus.dmem_rdata    = rdata;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectorCount = 0;
        failCount   = 0;
        rst         = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_result = '0; bus.ex_reg_dest = '0; bus.ex_write_en = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_mem_size = '0; bus.ex_mem_signed = 1'b0; bus.flush = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset wb_result", bus.wb_result, 32'h0);
        checkOutput("reset wb_write_en", {31'b0, bus.wb_write_en}, 32'h0);
        checkOutput("reset mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        checkOutput("reset dmem_req", {31'b0, bus.dmem_req}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // ALU op: registered pass-through, no stall
        applyStimulus(1, 32'h1234_5678, 5'd5, 1, 0, 2'b10, 0, 0, 0, 32'h0);
        checkOutput("alu mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        checkOutput("alu dmem_req", {31'b0, bus.dmem_req}, 32'h0);
        stepCycle();
        checkOutput("alu wb_result", bus.wb_result, 32'h1234_5678);
        checkOutput("alu wb_reg_dest", {27'b0, bus.wb_reg_dest}, 32'd5);
        checkOutput("alu wb_write_en", {31'b0, bus.wb_write_en}, 32'h1);

        // Signed byte load, lane 3, same-cycle ack
        applyStimulus(1, 32'h0000_0103, 5'd7, 1, 1, 2'b00, 1, 0, 1, 32'h80FF_0011);
        checkOutput("sbyte dmem_req", {31'b0, bus.dmem_req}, 32'h1);
        checkOutput("sbyte dmem_addr", bus.dmem_addr, 32'h0000_0100);
        checkOutput("sbyte mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        stepCycle();
        checkOutput("sbyte wb_result", bus.wb_result, 32'hFFFF_FF80);
        checkOutput("sbyte wb_write_en", {31'b0, bus.wb_write_en}, 32'h1);

        // Back-to-back unsigned variant, then signed lane 2
        applyStimulus(1, 32'h0000_0103, 5'd8, 1, 1, 2'b00, 0, 0, 1, 32'h80FF_0011);
        stepCycle();
        checkOutput("ubyte wb_result", bus.wb_result, 32'h0000_0080);
        checkOutput("ubyte wb_reg_dest", {27'b0, bus.wb_reg_dest}, 32'd8);
        applyStimulus(1, 32'h0000_0102, 5'd8, 1, 1, 2'b00, 1, 0, 1, 32'h80FF_0011);
        stepCycle();
        checkOutput("sbyte lane2 wb_result", bus.wb_result, 32'hFFFF_FFFF);

        // Signed half load acked after three stall cycles; execute result changes while waiting
        applyStimulus(1, 32'h0000_0202, 5'd9, 1, 1, 2'b01, 1, 0, 0, 32'h0);
        checkOutput("half c0 mem_stall", {31'b0, bus.mem_stall}, 32'h1);
        checkOutput("half c0 dmem_addr", bus.dmem_addr, 32'h0000_0200);
        stepCycle();
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1, 32'hDEAD_BEE1, 5'd9, 1, 1, 2'b00, 0, 0, 0, 32'h0);
            checkOutput("half wait mem_stall", {31'b0, bus.mem_stall}, 32'h1);
            checkOutput("half wait dmem_req", {31'b0, bus.dmem_req}, 32'h1);
            checkOutput("half wait dmem_addr", bus.dmem_addr, 32'h0000_0200);
            checkOutput("half wait wb_write_en", {31'b0, bus.wb_write_en}, 32'h0);
            stepCycle();
        end
        applyStimulus(1, 32'hDEAD_BEE1, 5'd9, 1, 1, 2'b00, 0, 0, 1, 32'hBEEF_0000);
        checkOutput("half ack mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        stepCycle();
        checkOutput("half wb_result", bus.wb_result, 32'hFFFF_BEEF);
        checkOutput("half wb_reg_dest", {27'b0, bus.wb_reg_dest}, 32'd9);
        checkOutput("half wb_write_en", {31'b0, bus.wb_write_en}, 32'h1);
        applyStimulus(0, 32'h0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
        stepCycle();
        checkOutput("bubble wb_write_en", {31'b0, bus.wb_write_en}, 32'h0);

        // Flush on the second wait cycle, ack two cycles later
        applyStimulus(1, 32'h0000_0300, 5'd10, 1, 1, 2'b10, 0, 0, 0, 32'h0);
        stepCycle();
        applyStimulus(1, 32'h0000_0300, 5'd10, 1, 1, 2'b10, 0, 0, 0, 32'h0);
        stepCycle();
        applyStimulus(1, 32'h0000_0300, 5'd10, 1, 1, 2'b10, 0, 1, 0, 32'h0);
        checkOutput("flush dmem_req", {31'b0, bus.dmem_req}, 32'h1);
        stepCycle();
        applyStimulus(1, 32'h0000_0300, 5'd10, 1, 1, 2'b10, 0, 0, 0, 32'h0);
        checkOutput("killed dmem_req", {31'b0, bus.dmem_req}, 32'h1);
        checkOutput("killed dmem_addr", bus.dmem_addr, 32'h0000_0300);
        stepCycle();
        applyStimulus(1, 32'h0000_0300, 5'd10, 1, 1, 2'b10, 0, 0, 1, 32'h1111_2222);
        checkOutput("killed ack mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        stepCycle();
        checkOutput("killed wb_write_en", {31'b0, bus.wb_write_en}, 32'h0);
        applyStimulus(1, 32'h0000_0304, 5'd11, 1, 1, 2'b10, 0, 0, 1, 32'hCAFE_BABE);
        checkOutput("after flush mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        stepCycle();
        checkOutput("after flush wb_result", bus.wb_result, 32'hCAFE_BABE);
        checkOutput("after flush wb_write_en", {31'b0, bus.wb_write_en}, 32'h1);

        // Flush of a load in IDLE issues nothing
        applyStimulus(1, 32'h0000_0308, 5'd12, 1, 1, 2'b10, 0, 1, 0, 32'h0);
        checkOutput("idle flush dmem_req", {31'b0, bus.dmem_req}, 32'h0);
        stepCycle();
        checkOutput("idle flush wb_write_en", {31'b0, bus.wb_write_en}, 32'h0);

        // Asynchronous reset in the middle of a wait
        applyStimulus(1, 32'h0000_0400, 5'd13, 1, 1, 2'b10, 0, 0, 0, 32'h0);
        stepCycle();
        checkOutput("pre-reset mem_stall", {31'b0, bus.mem_stall}, 32'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid reset wb_result", bus.wb_result, 32'h0);
        checkOutput("mid reset wb_reg_dest", {27'b0, bus.wb_reg_dest}, 32'h0);
        checkOutput("mid reset dmem_req", {31'b0, bus.dmem_req}, 32'h0);
        checkOutput("mid reset mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        checkOutput("mid reset dmem_addr", bus.dmem_addr, 32'h0);
        applyStimulus(0, 32'h0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
        #1 rst = 1'b0;
        stepCycle();
        checkOutput("post reset mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        applyStimulus(1, 32'h0000_0402, 5'd3, 1, 1, 2'b01, 0, 0, 1, 32'h1234_ABCD);
        stepCycle();
        checkOutput("post reset uhalf wb_result", bus.wb_result, 32'h0000_1234);
        checkOutput("post reset wb_write_en", {31'b0, bus.wb_write_en}, 32'h1);

        // Load to register 0 must not write
        applyStimulus(1, 32'h0000_0408, 5'd0, 1, 1, 2'b10, 0, 0, 1, 32'h0000_0055);
        stepCycle();
        checkOutput("dest0 wb_write_en", {31'b0, bus.wb_write_en}, 32'h0);

`ifdef LOAD_ALIGN_CHECK_EN
        // Misaligned word load traps instead of reaching memory
        applyStimulus(1, 32'h0000_0006, 5'd14, 1, 1, 2'b10, 0, 0, 0, 32'h0);
        checkOutput("misalign dmem_req", {31'b0, bus.dmem_req}, 32'h0);
        checkOutput("misalign mem_stall", {31'b0, bus.mem_stall}, 32'h0);
        stepCycle();
        checkOutput("misalign addr_error", {31'b0, bus.addr_error}, 32'h1);
        checkOutput("misalign wb_result", bus.wb_result, 32'h0000_0006);
        checkOutput("misalign wb_write_en", {31'b0, bus.wb_write_en}, 32'h0);
        applyStimulus(0, 32'h0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 32'h0);
        stepCycle();
        checkOutput("misalign pulse end", {31'b0, bus.addr_error}, 32'h0);
`else
        // Without the alignment check the low address bits are simply ignored
        applyStimulus(1, 32'h0000_0006, 5'd14, 1, 1, 2'b10, 0, 0, 1, 32'h1122_3344);
        checkOutput("unaligned dmem_req", {31'b0, bus.dmem_req}, 32'h1);
        checkOutput("unaligned dmem_addr", bus.dmem_addr, 32'h0000_0004);
        stepCycle();
        checkOutput("unaligned wb_result", bus.wb_result, 32'h1122_3344);
        checkOutput("unaligned addr_error", {31'b0, bus.addr_error}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_load_stage.md
Name: mem_load_stage

Overview:
- Memory-access stage directly upstream of the writeback stage.
- Takes execute-stage results and, for loads, runs a request/acknowledge transaction with data memory. Extracts and extends the addressed byte, half or word.
- Registers result, destination and write enable into the wb_* signals that the writeback stage passes on to the register file.
- Loads only; stores are issued by a separate store path.

Parameters:
- ADDR_W, 32, data-memory address width (bits).
- DATA_W, 32, data width; fixed at 32, and the lane logic assumes 32.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute-stage instruction present this cycle.
- ex_result  in  32  ALU result; for loads this is the effective address.
- ex_reg_dest  in  5  destination register.
- ex_write_en  in  1  instruction writes a register.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ex_mem_signed  in  1  1 = sign-extend, 0 = zero-extend.
- flush  in  1  kill the instruction in this stage.
- mem_stall  out  1  upstream must hold its ex_* inputs.
- dmem_req  out  1  data-memory read request.
- dmem_addr  out  32  word-aligned address: ex_result[31:2] followed by 2'b00.
- dmem_ack  in  1  read data valid this cycle.
- dmem_rdata  in  32  read data, little-endian.
- wb_result  out  32  to writeback stage.
- wb_reg_dest  out  5  to writeback stage.
- wb_write_en  out  1  to writeback stage.
- addr_error  out  1  misaligned-load pulse (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst high): state goes to IDLE; the killed flag and every registered output clear to 0. dmem_req and mem_stall are forced 0 while rst is high.
- Reset mid-WAIT abandons the transaction; data memory is reset by the same rst.
- State IDLE:
  - ex_valid and not ex_mem_read: capture ex_result, ex_reg_dest and ex_write_en into wb_*. Latency is 1 cycle.
  - ex_valid and ex_mem_read: dmem_req=1 combinationally, dmem_addr from ex_result.
    - dmem_ack the same cycle: capture the extracted data into wb_*, stay in IDLE.
    - No ack: latch address, size, sign, dest and write enable; go to WAIT; mem_stall=1.
  - Not ex_valid: wb_write_en is 0 next cycle (bubble).
- State WAIT:
  - dmem_req held at 1 and dmem_addr stable until ack.
  - mem_stall = not dmem_ack, so the upstream stage advances on the ack cycle.
  - wb_write_en is 0 every non-ack cycle.
  - On ack: capture the extracted data, go to IDLE.
- mem_stall = (IDLE and ex_valid and ex_mem_read and not dmem_ack) or (WAIT and not dmem_ack).
- Load extraction, with a = addr[1:0]:
  - Byte: byte lane a of rdata.
  - Half: bits [31:16] of rdata if addr[1]=1, else bits [15:0].
  - Word: rdata unchanged.
  - Byte and half results are sign- or zero-extended to 32 bits per ex_mem_signed.
- wb_write_en is forced 0 when the destination register is 0.
- Flush:
  - In IDLE: nothing is captured; wb_write_en=0 next cycle; no new dmem_req is issued.
  - In WAIT: the killed flag is set and dmem_req is held until ack, because the bus transaction must complete.
  - Ack arriving while killed: data is discarded, wb_write_en=0, killed clears.
  - Flush and ack in the same cycle discard that data.
- Back-to-back loads each acked in the same cycle sustain one load per cycle.

Optional Feature:
- Macro: LOAD_ALIGN_CHECK_EN.
- Defined:
  - A misaligned load is a half load with addr[0]=1, or a word load with addr[1:0] not 00.
  - It issues no dmem_req; next cycle addr_error=1 for exactly 1 cycle, wb_write_en=0, and wb_result holds the faulting address (for BadVAddr).
  - A flush in the same cycle suppresses addr_error.
- Not defined: addr_error is tied 0; low address bits that do not select a lane are ignored.

Decomposition:
- Shared package common_pkg:
  - mem_size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - mem_state_t enum (MS_IDLE, MS_WAIT).
  - Constant ZERO_REG = 5'd0.
- One combinational sub-module, load_extract: inputs rdata, addr[1:0], size and signed; output 32-bit load value. Reusable by the cache refill path.

Test Plan:
- ALU op: ex_result=32'h1234_5678, dest=5, write_en=1 -> next cycle wb_result=32'h1234_5678, wb_reg_dest=5, wb_write_en=1; mem_stall stays 0.
- Signed byte load, addr=32'h0000_0103, rdata=32'h80FF_0011, ack same cycle -> dmem_addr=32'h0000_0100; wb_result=32'hFFFF_FF80. Unsigned variant gives 32'h0000_0080.
- Half load, addr=32'h...2, ack after 3 wait cycles, rdata=32'hBEEF_0000, signed:
  - mem_stall=1 for 3 cycles, dmem_addr stable throughout.
  - wb_result=32'hFFFF_BEEF one cycle after ack; wb_write_en=0 during the wait.
- Flush asserted in the 2nd WAIT cycle, ack 2 cycles later -> dmem_req held until ack, no register write, returns to IDLE. The next load is accepted on the following cycle.
- rst pulsed during WAIT -> all outputs 0 immediately (asynchronous), state IDLE; a load after release behaves normally. A load with dest=0 gives wb_write_en=0.
- With LOAD_ALIGN_CHECK_EN, word load addr=32'h0000_0006 -> no dmem_req; addr_error=1 for one cycle; wb_result=32'h0000_0006; wb_write_en=0.
